// File: rtl/sprite_line_fetcher_if.sv
// Bus between the sprite line fetcher, its sprite RAM port and the video timing / colour mapper side.
interface sprite_line_fetcher_if #(
  parameter int ADDR_W = 11
);
  logic              enable;
  logic              hblank_start;
  logic [9:0]        next_line;
  logic [9:0]        draw_x;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic [1:0]        sprite_sel;
  logic              ram_cs;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rdata;
  logic [7:0]        pix_index;
  logic              pix_valid;
  logic              fetch_busy;

  modport master (
    output enable, hblank_start, next_line, draw_x, sprite_x, sprite_y, sprite_sel, ram_rdata,
    input  ram_cs, ram_addr, pix_index, pix_valid, fetch_busy
  );

  modport slave (
    input  enable, hblank_start, next_line, draw_x, sprite_x, sprite_y, sprite_sel, ram_rdata,
    output ram_cs, ram_addr, pix_index, pix_valid, fetch_busy
  );
endinterface

// File: rtl/sprite_line_fetcher.sv
// Prefetches one sprite row into a line buffer during hblank, then streams palette indices during active video.
module sprite_line_fetcher #(
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 32,
  parameter int SPR_WORDS = 512,
  parameter int ADDR_W    = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  sprite_line_fetcher_if.slave  bus
);
  localparam int WPR = SPR_W / 2;
  localparam int WW  = $clog2(WPR);

  typedef enum logic [1:0] {IDLE, CHECK, FETCH, LAST} state_t;

  state_t            state, state_nx;
  logic [WW-1:0]     w, w_nx;
  logic [9:0]        lx;
  logic [1:0]        lsel;
  logic              len;
  logic [10:0]       row;
  logic              line_hit;
  logic [15:0]       line_buf [WPR];

  logic              cs;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [WW-1:0]     wr_idx;
  logic              set_hit;

  logic [10:0]       col;
  logic              hit;
  logic [15:0]       word;
  logic [7:0]        idx;
  logic [7:0]        pix_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      w     <= '0;
    end else begin
      state <= state_nx;
      w     <= w_nx;
    end
  end

  // RAM data lags the address by one cycle, so each FETCH cycle stores the previous word.
  always_comb begin
    state_nx = state;
    w_nx     = w;
    cs       = 1'b0;
    addr     = '0;
    wr_en    = 1'b0;
    wr_idx   = w - WW'(1);
    set_hit  = 1'b0;
    case (state)
      IDLE: ;
      CHECK: begin
        if (len && !row[10] && row < 11'(SPR_H)) begin
          w_nx     = '0;
          state_nx = FETCH;
        end else begin
          state_nx = IDLE;
        end
      end
      FETCH: begin
        cs    = 1'b1;
        addr  = ADDR_W'(lsel) * ADDR_W'(SPR_WORDS) + ADDR_W'(row[9:0]) * ADDR_W'(WPR) + ADDR_W'(w);
        wr_en = (w != '0);
        w_nx  = w + WW'(1);
        if (w == WW'(WPR - 1)) state_nx = LAST;
      end
      LAST: begin
        wr_en    = 1'b1;
        wr_idx   = WW'(WPR - 1);
        set_hit  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.hblank_start) state_nx = CHECK;
  end

  assign col  = {1'b0, bus.draw_x} - {1'b0, lx};
  assign hit  = line_hit && !col[10] && col < 11'(SPR_W);
  assign word = line_buf[col[WW:1]];
  assign idx  = col[0] ? word[15:8] : word[7:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lx       <= '0;
      lsel     <= '0;
      len      <= 1'b0;
      row      <= '0;
      line_hit <= 1'b0;
      pix_q    <= '0;
      valid_q  <= 1'b0;
      for (int i = 0; i < WPR; i++) line_buf[i] <= '0;
    end else begin
      // A new hblank always wins, so an aborted fetch can never raise line_hit.
      if (bus.hblank_start) begin
        lx       <= bus.sprite_x;
        lsel     <= bus.sprite_sel;
        len      <= bus.enable;
        row      <= {1'b0, bus.next_line} - {1'b0, bus.sprite_y};
        line_hit <= 1'b0;
      end else if (set_hit) begin
        line_hit <= 1'b1;
      end
      if (wr_en) line_buf[wr_idx] <= bus.ram_rdata;
      pix_q   <= hit ? idx : 8'd0;
      valid_q <= hit && (idx != 8'd0);
    end
  end

  assign bus.ram_cs     = cs;
  assign bus.ram_addr   = addr;
  assign bus.pix_index  = pix_q;
  assign bus.pix_valid  = valid_q;
  assign bus.fetch_busy = (state != IDLE);
endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: 1-cycle-latency RAM model, table vectors, corner sequences, random lines.
module tb_sprite_line_fetcher;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sprite_line_fetcher_if #(.ADDR_W(11)) bus();
  sprite_line_fetcher dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [15:0] mem [2048];
  logic [15:0] rdata = 16'd0;
  always @(posedge clk) if (bus.ram_cs) rdata <= mem[bus.ram_addr];
  assign bus.ram_rdata = rdata;

  int addr_q[$];
  always @(posedge clk) if (reset_n && bus.ram_cs) addr_q.push_back(int'(bus.ram_addr));

  int total = 0;
  int bad = 0;

  // model of what the line buffer should hold: row `m_row` of image `m_sel`, placed at m_sx
  logic m_hit = 1'b0;
  int   m_sel = 0, m_row = 0, m_sx = 0;

  typedef struct {
    logic [9:0] x;
    logic [7:0] idx;
    logic       v;
  } vec_t;
  vec_t vt[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic int exp_pix(input int x);
    int col, wa;
    logic [15:0] wd;
    logic [7:0] ix;
    col = x - m_sx;
    if (!m_hit || col < 0 || col >= 32) return 0;
    wa = (m_sel * 512 + m_row * 16 + col / 2) % 2048;
    wd = mem[wa];
    ix = (col % 2 == 1) ? wd[15:8] : wd[7:0];
    return (ix == 8'd0) ? 0 : (256 | int'(ix));
  endfunction

  task automatic chk_pix(input int x, input string nm);
    bus.draw_x = 10'(x);
    tick;
    chk(nm, int'({bus.pix_valid, bus.pix_index}), exp_pix(x));
  endtask

  task automatic finish_fetch(input string tag, input int sel, input int row, input logic hit, input int sx);
    int n, cyc, vcnt, mm;
    n = 0; cyc = 0; vcnt = 0;
    while (bus.fetch_busy && cyc < 60) begin
      n++;
      if (n >= 2 && bus.pix_valid) vcnt++;
      tick;
      cyc++;
    end
    chk({tag, " timeout"}, int'(cyc >= 60), 0);
    chk({tag, " busy cycles"}, n, hit ? 18 : 1);
    chk({tag, " valid while fetching"}, vcnt, 0);
    chk({tag, " addr count"}, addr_q.size(), hit ? 16 : 0);
    mm = 0;
    if (hit && addr_q.size() == 16)
      for (int j = 0; j < 16; j++)
        if (addr_q[j] != (sel * 512 + row * 16 + j) % 2048) mm++;
    chk({tag, " addr mismatches"}, mm, 0);
    m_hit = hit; m_sel = sel; m_row = row; m_sx = sx;
  endtask

  task automatic load_line(input int sel, input int sy, input int nl, input int sx, input logic en, input string tag);
    int row;
    bus.sprite_sel = 2'(sel); bus.sprite_y = 10'(sy); bus.next_line = 10'(nl);
    bus.sprite_x = 10'(sx); bus.enable = en; bus.hblank_start = 1'b1;
    tick;
    bus.hblank_start = 1'b0;
    addr_q.delete();
    row = nl - sy;
    finish_fetch(tag, sel, row, en && row >= 0 && row < 32, sx);
  endtask

  initial begin
    logic [7:0] lo;
    int cnt, sy, nl, sx;
    logic en;

    for (int k = 0; k < 2048; k++) begin
      lo = 8'(k);
      mem[k] = {lo + 8'd1, lo};
    end
    vt[0] = '{10'd198, 8'h00, 1'b0};
    vt[1] = '{10'd199, 8'h00, 1'b0};
    vt[2] = '{10'd200, 8'h50, 1'b1};
    vt[3] = '{10'd201, 8'h51, 1'b1};
    vt[4] = '{10'd215, 8'h58, 1'b1};
    vt[5] = '{10'd230, 8'h5F, 1'b1};
    vt[6] = '{10'd231, 8'h60, 1'b1};
    vt[7] = '{10'd232, 8'h00, 1'b0};

    bus.enable = 1'b0; bus.hblank_start = 1'b0; bus.next_line = '0; bus.draw_x = '0;
    bus.sprite_x = '0; bus.sprite_y = '0; bus.sprite_sel = '0;
    tick; tick; tick;
    chk("reset ram_cs", int'(bus.ram_cs), 0);
    chk("reset ram_addr", int'(bus.ram_addr), 0);
    chk("reset pix_index", int'(bus.pix_index), 0);
    chk("reset pix_valid", int'(bus.pix_valid), 0);
    chk("reset fetch_busy", int'(bus.fetch_busy), 0);
    reset_n = 1'b1;
    tick;

    // basic row fetch, sel 1 row 5
    load_line(1, 100, 105, 200, 1'b1, "t1");
    chk("t1 first addr", addr_q.size() > 0 ? addr_q[0] : -1, 592);
    chk("t1 last addr", addr_q.size() > 15 ? addr_q[15] : -1, 607);

    for (int i = 0; i < 8; i++) begin
      bus.draw_x = vt[i].x;
      tick;
      chk($sformatf("vec x=%0d", vt[i].x), int'({bus.pix_valid, bus.pix_index}), int'({vt[i].v, vt[i].idx}));
    end
    for (int x = 198; x <= 233; x++) chk_pix(x, $sformatf("t2 sweep x=%0d", x));

    // transparent low byte in word 600 -> columns 16/17
    mem[600] = 16'h5900;
    load_line(1, 100, 105, 200, 1'b1, "t3");
    bus.draw_x = 10'd216; tick;
    chk("t3 even transparent", int'({bus.pix_valid, bus.pix_index}), 0);
    bus.draw_x = 10'd217; tick;
    chk("t3 odd opaque", int'({bus.pix_valid, bus.pix_index}), 256 | 8'h59);

    // rows just outside the sprite
    load_line(1, 100, 99, 200, 1'b1, "t4a");
    cnt = 0;
    for (int x = 0; x < 640; x++) begin bus.draw_x = 10'(x); tick; if (bus.pix_valid) cnt++; end
    chk("t4a valid count", cnt, 0);
    load_line(1, 100, 105, 200, 1'b1, "t4 reload");
    load_line(1, 100, 132, 200, 1'b1, "t4b");
    cnt = 0;
    for (int x = 190; x < 240; x++) begin bus.draw_x = 10'(x); tick; if (bus.pix_valid) cnt++; end
    chk("t4b valid count", cnt, 0);

    // abort at w=7, restart at row 10
    bus.draw_x = 10'd200;
    bus.sprite_sel = 2'd1; bus.sprite_y = 10'd100; bus.next_line = 10'd105;
    bus.sprite_x = 10'd200; bus.enable = 1'b1; bus.hblank_start = 1'b1;
    tick;
    bus.hblank_start = 1'b0;
    cnt = 0;
    while (!(bus.ram_cs && bus.ram_addr == 11'd599) && cnt < 30) begin tick; cnt++; end
    chk("t5 reach w7", int'(cnt >= 30), 0);
    bus.next_line = 10'd110; bus.hblank_start = 1'b1;
    tick;
    bus.hblank_start = 1'b0;
    addr_q.delete();
    finish_fetch("t5", 1, 10, 1'b1, 200);
    chk_pix(200, "t5 new row x=200");
    chk_pix(203, "t5 new row x=203");

    // reset in the middle of a fetch
    bus.next_line = 10'd105; bus.hblank_start = 1'b1;
    tick;
    bus.hblank_start = 1'b0;
    tick; tick; tick; tick;
    reset_n = 1'b0;
    tick;
    chk("t6 ram_cs", int'(bus.ram_cs), 0);
    chk("t6 fetch_busy", int'(bus.fetch_busy), 0);
    chk("t6 pix_valid", int'(bus.pix_valid), 0);
    reset_n = 1'b1;
    m_hit = 1'b0;
    chk_pix(200, "t6 after x=200");
    chk_pix(201, "t6 after x=201");

    // right-edge clipping
    load_line(1, 100, 105, 620, 1'b1, "t7");
    bus.draw_x = 10'd619; tick;
    chk("t7 x=619", int'({bus.pix_valid, bus.pix_index}), 0);
    bus.draw_x = 10'd620; tick;
    chk("t7 x=620", int'({bus.pix_valid, bus.pix_index}), 256 | 8'h50);
    bus.draw_x = 10'd639; tick;
    chk("t7 x=639", int'({bus.pix_valid, bus.pix_index}), 256 | 8'h5A);
    cnt = 0;
    for (int x = 0; x < 12; x++) begin bus.draw_x = 10'(x); tick; if (bus.pix_valid) cnt++; end
    chk("t7 no wrap", cnt, 0);
    for (int x = 610; x < 640; x++) chk_pix(x, $sformatf("t7 sweep x=%0d", x));

    // random lines; inputs scrambled after the latch to check they are held
    for (int l = 0; l < 10; l++) begin
      sy = int'($urandom_range(10, 400));
      nl = sy + int'($urandom_range(0, 44)) - 4;
      sx = int'($urandom_range(0, 639));
      en = ($urandom_range(0, 3) != 0);
      load_line(int'($urandom_range(0, 3)), sy, nl, sx, en, $sformatf("rnd%0d", l));
      bus.sprite_x = 10'($urandom); bus.sprite_y = 10'($urandom);
      bus.sprite_sel = 2'($urandom); bus.enable = 1'($urandom);
      for (int k = 0; k < 40; k++)
        chk_pix((sx + int'($urandom_range(0, 40)) - 4) & 1023, $sformatf("rnd%0d pix", l));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
